// File: rtl/approx_accuracy_ctrl_multiplier.sv
// Multi-cycle 32x32 unsigned multiplier with run-time accuracy control.
// Each 16x16 quarter product is built from four 8x8 approximate units. In
// those units the low partial-product columns are either summed exactly or
// OR-collapsed, selected per column by the latched Er vector.

// 8x8 approximate multiplier: the columns below ER_WIDTH are exact only when
// their Er bit is set, otherwise they contribute the OR of their pp bits.
module approx_mul8 #(
    parameter int ER_WIDTH = 7
) (
    input  logic [7:0]          a_i,
    input  logic [7:0]          b_i,
    input  logic [ER_WIDTH-1:0] er_i,
    output logic [15:0]         p_o
);
    logic [14:0][3:0] col_cnt;
    logic [14:0]      col_any;
    logic [14:0]      col_exact;
    logic [15:0]      sum;

    // Columns at or above ER_WIDTH are always exact.
    assign col_exact = {{(15-ER_WIDTH){1'b1}}, er_i};

    // Count set partial-product bits per column and note whether any are set.
    always_comb begin
        col_cnt = '0;
        col_any = '0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                if (a_i[i] & b_i[j]) begin
                    col_cnt[i+j] = col_cnt[i+j] + 4'd1;
                    col_any[i+j] = 1'b1;
                end
            end
        end
    end

    // Weight each column by its exact count or its OR bit. The approximate
    // contribution never exceeds the exact one, so 16 bits always suffice.
    always_comb begin
        sum = '0;
        for (int c = 0; c < 15; c++) begin
            if (col_exact[c])
                sum = sum + (16'(col_cnt[c]) << c);
            else
                sum = sum + (16'(col_any[c]) << c);
        end
    end

    assign p_o = sum;
endmodule

module approx_accuracy_ctrl_multiplier #(
    parameter int len      = 32,
    parameter int ER_WIDTH = 7
) (
    input  logic                CLK,
    input  logic                reset,
    input  logic                enable,
    input  logic [ER_WIDTH-1:0] Er,
    input  logic [len-1:0]      Multiplicand,
    input  logic [len-1:0]      Multiplier,
    output logic [2*len-1:0]    Product,
    output logic                Busy
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          step_q, step_d;
    logic [63:0]         acc_q, acc_d;
    logic [63:0]         product_q, product_d;
    logic                busy_q, busy_d;
    logic [31:0]         a_q, a_d;
    logic [31:0]         b_q, b_d;
    logic [ER_WIDTH-1:0] er_q, er_d;

    logic [15:0]         a_half, b_half;
    logic [3:0][7:0]     ua, ub;
    logic [3:0][15:0]    up;
    logic [31:0]         sub_prod;
    logic [63:0]         sub_shifted;

    // Step bit 0 picks the A half, step bit 1 picks the B half.
    assign a_half = step_q[0] ? a_q[31:16] : a_q[15:0];
    assign b_half = step_q[1] ? b_q[31:16] : b_q[15:0];

    // Unit order: lo*lo, hi*lo, lo*hi, hi*hi (A byte * B byte).
    assign ua[0] = a_half[7:0];
    assign ub[0] = b_half[7:0];
    assign ua[1] = a_half[15:8];
    assign ub[1] = b_half[7:0];
    assign ua[2] = a_half[7:0];
    assign ub[2] = b_half[15:8];
    assign ua[3] = a_half[15:8];
    assign ub[3] = b_half[15:8];

    for (genvar g = 0; g < 4; g++) begin : g_unit
        approx_mul8 #(.ER_WIDTH(ER_WIDTH)) u_mul8 (
            .a_i  (ua[g]),
            .b_i  (ub[g]),
            .er_i (er_q),
            .p_o  (up[g])
        );
    end

    // Each unit result is bounded by the exact byte product, so the 16x16
    // sum fits in 32 bits.
    assign sub_prod = {16'b0, up[0]}
                    + {8'b0, up[1], 8'b0}
                    + {8'b0, up[2], 8'b0}
                    + {up[3], 16'b0};

    // Quarter-product alignment: 16 * (number of high halves used).
    always_comb begin
        sub_shifted = {32'b0, sub_prod};
        case (step_q)
            2'd0:    sub_shifted = {32'b0, sub_prod};
            2'd1,
            2'd2:    sub_shifted = {16'b0, sub_prod, 16'b0};
            default: sub_shifted = {sub_prod, 32'b0};
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            acc_q     <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            er_q      <= '0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            a_q       <= a_d;
            b_q       <= b_d;
            er_q      <= er_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = CALC;
            CALC:    if (step_q == 2'd3) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-values; operands only load in IDLE, so
    // input changes during an operation are ignored.
    always_comb begin
        step_d    = step_q;
        acc_d     = acc_q;
        product_d = product_q;
        busy_d    = busy_q;
        a_d       = a_q;
        b_d       = b_q;
        er_d      = er_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    a_d    = Multiplicand;
                    b_d    = Multiplier;
                    er_d   = Er;
                    acc_d  = '0;
                    step_d = '0;
                    busy_d = 1'b1;
                end
            end
            CALC: begin
                acc_d  = acc_q + sub_shifted;
                step_d = step_q + 2'd1;
            end
            DONE: begin
                product_d = acc_q;
                busy_d    = 1'b0;
            end
            default: ;
        endcase
    end

    assign Product = product_q;
    assign Busy    = busy_q;
endmodule

// File: tb/tb_approx_accuracy_ctrl_multiplier.sv
// Self-checking bench: directed cases plus randomized runs against a
// byte-level model of the column-OR approximation.
module tb_approx_accuracy_ctrl_multiplier;
    logic        CLK = 1'b0;
    logic        reset;
    logic        enable;
    logic [6:0]  Er;
    logic [31:0] Multiplicand;
    logic [31:0] Multiplier;
    logic [63:0] Product;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    approx_accuracy_ctrl_multiplier #(.len(32), .ER_WIDTH(7)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .enable       (enable),
        .Er           (Er),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .Product      (Product),
        .Busy         (Busy)
    );

    always #5 CLK = ~CLK;

    // Byte model: exact product, minus the surplus of every OR-collapsed
    // column (n set bits become a single bit of that column's weight).
    function automatic logic [15:0] m8(logic [7:0] a, logic [7:0] b, logic [6:0] er);
        int unsigned r;
        int unsigned n;
        r = int'(a) * int'(b);
        for (int k = 0; k < 7; k++) begin
            if (!er[k]) begin
                n = 0;
                for (int i = 0; i <= k; i++)
                    if (a[i] & b[k-i]) n++;
                if (n > 1) r = r - ((n - 1) << k);
            end
        end
        return r[15:0];
    endfunction

    // Full product as the sum of all 16 byte-pair products.
    function automatic logic [63:0] m32(logic [31:0] a, logic [31:0] b, logic [6:0] er);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r = r + (64'(m8(a[8*i+:8], b[8*j+:8], er)) << (8*(i+j)));
        return r;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pulse enable for one edge, then count Busy cycles (bounded) and check.
    task automatic run_op(string tag, logic [31:0] a, logic [31:0] b, logic [6:0] er,
                          logic [63:0] exp);
        int cyc;
        Multiplicand = a;
        Multiplier   = b;
        Er           = er;
        enable       = 1'b1;
        @(posedge CLK); #1;
        enable = 1'b0;
        cyc = 0;
        while (Busy && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk({tag, "_busy_cycles"}, 64'(cyc), 64'd5);
        chk({tag, "_product"}, Product, exp);
    endtask

    initial begin
        int          cyc;
        logic [31:0] ra, rb;
        logic [6:0]  rer;

        reset = 1'b1; enable = 1'b0; Er = '0; Multiplicand = '0; Multiplier = '0;
        @(posedge CLK); @(posedge CLK); #1;
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_product", Product, 64'd0);
        reset = 1'b0;
        @(posedge CLK); #1;

        run_op("exact_0d_15", 32'h0D0D0D0D, 32'h15151515, 7'h7F, 64'h0113253747352311);
        run_op("exact_ff_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 7'h7F, 64'hFFFFFFFE00000001);
        run_op("zero_a", 32'h0, 32'hDEADBEEF, 7'h7F, 64'd0);
        run_op("approx_3x3", 32'd3, 32'd3, 7'h00, 64'd7);
        run_op("exact_3x3", 32'd3, 32'd3, 7'h7F, 64'd9);
        run_op("approx_ff_ff", 32'hFFFFFFFF, 32'hFFFFFFFF, 7'h00,
               m32(32'hFFFFFFFF, 32'hFFFFFFFF, 7'h00));

        // Operands/Er change and enable stays high during Busy.
        Multiplicand = 32'h12345678; Multiplier = 32'h9ABCDEF1; Er = 7'h55;
        enable = 1'b1;
        @(posedge CLK); #1;
        Multiplicand = 32'hFFFF0000; Multiplier = 32'h0000FFFF; Er = 7'h00;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        enable = 1'b0;
        cyc = 2;
        while (Busy && cyc < 20) begin
            @(posedge CLK); #1;
            cyc++;
        end
        chk("hold_busy_cycles", 64'(cyc), 64'd5);
        chk("hold_product", Product, m32(32'h12345678, 32'h9ABCDEF1, 7'h55));
        @(posedge CLK); #1;
        chk("hold_no_restart", 64'(Busy), 64'd0);

        // Reset mid-operation, then a clean start.
        Multiplicand = 32'hCAFEBABE; Multiplier = 32'h01234567; Er = 7'h7F;
        enable = 1'b1;
        @(posedge CLK); #1;
        enable = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        reset = 1'b1;
        @(posedge CLK); #1;
        chk("midreset_busy", 64'(Busy), 64'd0);
        chk("midreset_product", Product, 64'd0);
        reset = 1'b0;
        @(posedge CLK); #1;
        run_op("after_reset", 32'hCAFEBABE, 32'h01234567, 7'h7F,
               64'(32'hCAFEBABE) * 64'(32'h01234567));

        for (int n = 0; n < 200; n++) begin
            ra = $urandom; rb = $urandom;
            run_op("rand_exact", ra, rb, 7'h7F, 64'(ra) * 64'(rb));
        end
        for (int n = 0; n < 100; n++) begin
            ra = $urandom; rb = $urandom; rer = 7'($urandom);
            run_op("rand_er", ra, rb, rer, m32(ra, rb, rer));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
